// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU types for the fetch stage.
//   word_t         : 32-bit machine word (instructions, addresses).
//   fetch_state_t  : fetch FSM state (FETCH, HOLD, HALTED).
//   pc_incr()      : sequential next-PC helper, modulo 2^32.
// -----------------------------------------------------------------------------
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam word_t PC_STEP = 32'd4;

  // Sequential successor of a PC; wraps naturally at 2^32 and never
  // touches the two low bits because the step is a multiple of four.
  function automatic word_t pc_incr(input word_t pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
// Program counter register with load / increment / hold.
// Ports:
//   clk_i       : rising-edge clock
//   rst_ni      : asynchronous active-low reset, loads PC_INIT
//   load_i      : load load_pc_i (takes priority over inc_i)
//   load_pc_i   : value to load
//   inc_i       : advance PC by four
//   pc_o        : current PC
//   pc_plus4_o  : current PC + 4 (modulo 2^32)
// -----------------------------------------------------------------------------
module pc_reg
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  load_i,
  input  word_t load_pc_i,
  input  logic  inc_i,
  output word_t pc_o,
  output word_t pc_plus4_o
);

  word_t pc_q;
  word_t pc_d;

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_incr(pc_q);

  // Next-PC select: load beats increment, otherwise hold.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_pc_i;
    end else if (inc_i) begin
      pc_d = pc_plus4_o;
    end else begin
      pc_d = pc_q;
    end
  end

  // PC state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= PC_INIT;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage with IF/ID pipeline register and a one-entry
// skid buffer that catches a word returned while the hazard unit stalls.
// Ports:
//   CLK, nRST      : clock, asynchronous active-low reset
//   ihit, iload    : instruction memory handshake and returned word
//   iREN, iaddr    : read request (only in FETCH) and fetch address (= PC)
//   stall, flush   : hazard controls for the IF/ID register
//   redirect,
//   redirect_pc    : taken control transfer resolved downstream
//   halt           : HALT seen in IF/ID; parks the stage until reset
//   instr, npc,
//   valid          : IF/ID contents (instr=0/valid=0 is a bubble)
// -----------------------------------------------------------------------------
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] instr,
  output logic [31:0] npc,
  output logic        valid
);

  fetch_state_t state_q, state_d;
  word_t        instr_q, instr_d;
  word_t        npc_q, npc_d;
  logic         valid_q, valid_d;
  word_t        buf_instr_q, buf_instr_d;
  word_t        buf_npc_q, buf_npc_d;

  logic         pc_load_s;
  logic         pc_inc_s;
  word_t        pc_s;
  word_t        pc_plus4_s;

  pc_reg #(
    .PC_INIT (PC_INIT)
  ) u_pc_reg (
    .clk_i      (CLK),
    .rst_ni     (nRST),
    .load_i     (pc_load_s),
    .load_pc_i  (redirect_pc),
    .inc_i      (pc_inc_s),
    .pc_o       (pc_s),
    .pc_plus4_o (pc_plus4_s)
  );

  assign iREN  = (state_q == FETCH);
  assign iaddr = pc_s;
  assign instr = instr_q;
  assign npc   = npc_q;
  assign valid = valid_q;

  // Next-state logic: halt > redirect > stall > normal; flush then
  // overrides whatever the IF/ID register would have loaded.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    npc_d       = npc_q;
    valid_d     = valid_q;
    buf_instr_d = buf_instr_q;
    buf_npc_d   = buf_npc_q;
    pc_load_s   = 1'b0;
    pc_inc_s    = 1'b0;

    case (state_q)
      FETCH: begin
        if (halt) begin
          state_d = HALTED;
          instr_d = 32'h0000_0000;
          valid_d = 1'b0;
        end else if (redirect) begin
          // Any word returned this cycle belongs to the wrong path.
          pc_load_s = 1'b1;
          instr_d   = 32'h0000_0000;
          valid_d   = 1'b0;
        end else if (ihit) begin
          pc_inc_s = 1'b1;
          if (stall) begin
            // IF/ID is frozen, so park the returned word in the buffer.
            buf_instr_d = iload;
            buf_npc_d   = pc_plus4_s;
            state_d     = HOLD;
          end else begin
            instr_d = iload;
            npc_d   = pc_plus4_s;
            valid_d = 1'b1;
          end
        end else begin
          if (stall) begin
            state_d = FETCH;
          end else begin
            instr_d = 32'h0000_0000;
            valid_d = 1'b0;
          end
        end
      end

      HOLD: begin
        if (halt) begin
          state_d = HALTED;
          instr_d = 32'h0000_0000;
          valid_d = 1'b0;
        end else if (redirect) begin
          pc_load_s   = 1'b1;
          instr_d     = 32'h0000_0000;
          valid_d     = 1'b0;
          buf_instr_d = 32'h0000_0000;
          buf_npc_d   = 32'h0000_0000;
          state_d     = FETCH;
        end else if (stall) begin
          state_d = HOLD;
        end else begin
          // PC already advanced when the word was buffered.
          instr_d     = buf_instr_q;
          npc_d       = buf_npc_q;
          valid_d     = 1'b1;
          buf_instr_d = 32'h0000_0000;
          buf_npc_d   = 32'h0000_0000;
          state_d     = FETCH;
        end
      end

      HALTED: begin
        // Only nRST leaves this state.
        state_d = HALTED;
        instr_d = 32'h0000_0000;
        valid_d = 1'b0;
      end

      default: begin
        state_d = FETCH;
        instr_d = 32'h0000_0000;
        valid_d = 1'b0;
      end
    endcase

    if (flush) begin
      instr_d = 32'h0000_0000;
      valid_d = 1'b0;
    end else begin
      valid_d = valid_d;
    end
  end

  // FSM, IF/ID and skid-buffer registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= FETCH;
      instr_q     <= 32'h0000_0000;
      npc_q       <= 32'h0000_0000;
      valid_q     <= 1'b0;
      buf_instr_q <= 32'h0000_0000;
      buf_npc_q   <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      npc_q       <= npc_d;
      valid_q     <= valid_d;
      buf_instr_q <= buf_instr_d;
      buf_npc_q   <= buf_npc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        CLK;
  logic        nRST;
  logic        ihit;
  logic [31:0] iload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] instr;
  logic [31:0] npc;
  logic        valid;

  int n_total;
  int n_pass;

  fetch_unit #(
    .PC_INIT (32'h0000_0000)
  ) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .ihit        (ihit),
    .iload       (iload),
    .iREN        (iREN),
    .iaddr       (iaddr),
    .stall       (stall),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .instr       (instr),
    .npc         (npc),
    .valid       (valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] ei, input logic [31:0] en,
                          input logic ev);
    chk({tag, ".instr"}, instr, ei);
    chk({tag, ".npc"}, npc, en);
    chk({tag, ".valid"}, {31'd0, valid}, {31'd0, ev});
  endtask

  task automatic chk_fe(input string tag, input logic [31:0] ea, input logic er);
    chk({tag, ".iaddr"}, iaddr, ea);
    chk({tag, ".iREN"}, {31'd0, iREN}, {31'd0, er});
  endtask

  initial begin
    n_total = 0;
    n_pass = 0;
    nRST = 1'b0; ihit = 1'b0; iload = 32'h0; stall = 1'b0; flush = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0; halt = 1'b0;

    // Reset state
    step();
    chk_fe("rst", 32'h0000_0000, 1'b1);
    chk_ifid("rst", 32'h0, 32'h0, 1'b0);

    // Streaming fetch at full ihit rate
    nRST = 1'b1; ihit = 1'b1; iload = 32'h3C01_0001;
    #1 chk_fe("s0", 32'h0000_0000, 1'b1);
    step();
    chk_fe("s1", 32'h0000_0004, 1'b1);
    chk_ifid("s1", 32'h3C01_0001, 32'h0000_0004, 1'b1);
    step();
    chk_fe("s2", 32'h0000_0008, 1'b1);
    chk_ifid("s2", 32'h3C01_0001, 32'h0000_0008, 1'b1);
    step();
    step();
    chk_fe("s4", 32'h0000_0010, 1'b1);
    chk_ifid("s4", 32'h3C01_0001, 32'h0000_0010, 1'b1);

    // ihit with stall at PC=0x10 -> HOLD for three cycles
    iload = 32'h1111_2222; stall = 1'b1;
    step();
    chk_fe("h1", 32'h0000_0014, 1'b0);
    chk_ifid("h1", 32'h3C01_0001, 32'h0000_0010, 1'b1);
    iload = 32'hDEAD_BEEF;
    step();
    chk_fe("h2", 32'h0000_0014, 1'b0);
    step();
    chk_fe("h3", 32'h0000_0014, 1'b0);
    chk_ifid("h3", 32'h3C01_0001, 32'h0000_0010, 1'b1);
    stall = 1'b0; ihit = 1'b0;
    step();
    chk_fe("hrel", 32'h0000_0014, 1'b1);
    chk_ifid("hrel", 32'h1111_2222, 32'h0000_0014, 1'b1);

    // Redirect coincident with ihit drops the word
    ihit = 1'b1; iload = 32'h5555_6666; redirect = 1'b1; redirect_pc = 32'h0000_0040;
    step();
    chk_fe("redir", 32'h0000_0040, 1'b1);
    chk("redir.instr", instr, 32'h0);
    chk("redir.valid", {31'd0, valid}, 32'd0);
    redirect = 1'b0; iload = 32'h2000_0040;
    step();
    chk_ifid("tgt", 32'h2000_0040, 32'h0000_0044, 1'b1);

    // No ihit, no stall -> bubble, PC held
    ihit = 1'b0;
    step();
    chk_fe("bub", 32'h0000_0044, 1'b1);
    chk_ifid("bub", 32'h0, 32'h0000_0044, 1'b0);

    // No ihit with stall -> everything holds
    ihit = 1'b1; iload = 32'hABCD_0048;
    step();
    ihit = 1'b0; stall = 1'b1;
    step();
    chk_fe("nhs", 32'h0000_0048, 1'b1);
    chk_ifid("nhs", 32'hABCD_0048, 32'h0000_0048, 1'b1);

    // PC wrap at top of address space
    stall = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    chk_fe("wr0", 32'hFFFF_FFFC, 1'b1);
    redirect = 1'b0; ihit = 1'b1; iload = 32'h1234_5678;
    step();
    chk_fe("wrap", 32'h0000_0000, 1'b1);
    chk_ifid("wrap", 32'h1234_5678, 32'h0000_0000, 1'b1);

    // flush + stall with ihit: IF/ID squashed, word buffered
    stall = 1'b1; flush = 1'b1; iload = 32'h0000_9999;
    step();
    chk_fe("fl", 32'h0000_0004, 1'b0);
    chk("fl.instr", instr, 32'h0);
    chk("fl.valid", {31'd0, valid}, 32'd0);
    flush = 1'b0; stall = 1'b0; ihit = 1'b0;
    step();
    chk_ifid("flrel", 32'h0000_9999, 32'h0000_0004, 1'b1);

    // halt while stalled -> HALTED until reset, redirect ignored
    stall = 1'b1; halt = 1'b1; ihit = 1'b1; iload = 32'h7777_0000;
    step();
    chk_fe("hlt", 32'h0000_0004, 1'b0);
    chk("hlt.valid", {31'd0, valid}, 32'd0);
    chk("hlt.instr", instr, 32'h0);
    halt = 1'b0; stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0100;
    step();
    step();
    chk_fe("hlt2", 32'h0000_0004, 1'b0);
    chk("hlt2.valid", {31'd0, valid}, 32'd0);
    redirect = 1'b0;

    // Reset exits HALTED
    nRST = 1'b0;
    #1 chk_fe("hrst", 32'h0000_0000, 1'b1);
    @(negedge CLK);
    nRST = 1'b1; ihit = 1'b1; stall = 1'b1; iload = 32'h7777_0001;
    step();
    chk_fe("hold2", 32'h0000_0004, 1'b0);

    // Asynchronous reset mid-HOLD
    #2 nRST = 1'b0;
    #1;
    chk_fe("arst", 32'h0000_0000, 1'b1);
    chk_ifid("arst", 32'h0, 32'h0, 1'b0);
    @(negedge CLK);
    nRST = 1'b1; stall = 1'b0; ihit = 1'b1; iload = 32'h8888_0000;
    step();
    chk_fe("post", 32'h0000_0004, 1'b1);
    chk_ifid("post", 32'h8888_0000, 32'h0000_0004, 1'b1);
    ihit = 1'b0;
    step();
    chk_ifid("nobuf", 32'h0, 32'h0000_0004, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
